// File: rtl/i2c_auto_init_sequencer.sv
// Power-up register loader: walks a table of {reg_addr, reg_data} entries and
// drives an I2C byte-level controller with one write transaction per entry.
// NACKed transactions are retried after an idle gap; exhausted retries set a
// sticky error that records the first failing entry index.
module i2c_auto_init_sequencer #(
  parameter int         NUM_ENTRIES = 20,
  parameter int         IDX_W       = 5,
  parameter logic [6:0] DEVICE_ADDR = 7'h1A,
  parameter int         ADDR_BYTES  = 1,
  parameter int         DATA_BYTES  = 1,
  parameter int         MAX_RETRIES = 2,
  parameter int         RETRY_GAP   = 1000
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  restart,
  input  logic                                  clear_error,
  input  logic [8*(ADDR_BYTES+DATA_BYTES)-1:0]  rom_data,
  input  logic                                  ack,
  input  logic                                  transfer_complete,
  output logic [IDX_W-1:0]                      rom_address,
  output logic [7:0]                            data_out,
  output logic [2:0]                            data_size,
  output logic                                  transfer_data,
  output logic                                  send_start_bit,
  output logic                                  send_stop_bit,
  output logic                                  busy,
  output logic                                  auto_init_complete,
  output logic                                  auto_init_error,
  output logic [IDX_W-1:0]                      error_index
);

  localparam int               NBYTES    = 1 + ADDR_BYTES + DATA_BYTES;
  localparam logic [2:0]       LAST_BYTE = 3'(NBYTES - 1);
  localparam logic [IDX_W-1:0] END_IDX   = IDX_W'(NUM_ENTRIES);
  localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRIES);
  localparam logic [15:0]      GAP_LAST  = 16'(RETRY_GAP - 1);

  typedef enum logic [3:0] {
    S_CHECK,
    S_START,
    S_BYTE,
    S_WAIT,
    S_STOP,
    S_EVAL,
    S_GAP,
    S_NEXT,
    S_DONE
  } state_t;

  state_t      state;
  state_t      pending;
  logic [2:0]  byte_idx;
  logic [2:0]  retry_cnt;
  logic        nack_flag;
  logic [15:0] gap_cnt;
  logic [7:0]  sel_byte;

  // Byte 0 is the write address of the device; later bytes come from the entry, MSB byte first.
  always_comb begin
    sel_byte = {DEVICE_ADDR, 1'b0};
    for (int unsigned i = 1; i < NBYTES; i++) begin
      if (byte_idx == 3'(i)) sel_byte = rom_data[8*(NBYTES-1-i) +: 8];
    end
  end

  assign busy               = (state != S_DONE);
  assign auto_init_complete = (state == S_DONE);

  // Sequencer FSM with registered controller requests, retry/gap counters and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_CHECK;
      pending         <= S_CHECK;
      rom_address     <= '0;
      data_out        <= '0;
      data_size       <= '0;
      transfer_data   <= 1'b0;
      send_start_bit  <= 1'b0;
      send_stop_bit   <= 1'b0;
      auto_init_error <= 1'b0;
      error_index     <= '0;
      byte_idx        <= '0;
      retry_cnt       <= '0;
      nack_flag       <= 1'b0;
      gap_cnt         <= '0;
    end else begin
      // A failure flagged in S_EVAL below overrides this clear in the same cycle.
      if (clear_error) begin
        auto_init_error <= 1'b0;
        error_index     <= '0;
      end

      case (state)
        S_CHECK: begin
          state <= (rom_address >= END_IDX) ? S_DONE : S_START;
        end

        S_START: begin
          if (send_start_bit && transfer_complete) begin
            send_start_bit <= 1'b0;
            byte_idx       <= '0;
            nack_flag      <= 1'b0;
            pending        <= S_BYTE;
            state          <= S_WAIT;
          end else begin
            send_start_bit <= 1'b1;
          end
        end

        S_BYTE: begin
          if (transfer_data && transfer_complete) begin
            transfer_data <= 1'b0;
            nack_flag     <= nack_flag | ack;
            if (byte_idx == LAST_BYTE) begin
              pending <= S_STOP;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              pending  <= S_BYTE;
            end
            state <= S_WAIT;
          end else begin
            transfer_data <= 1'b1;
            data_out      <= sel_byte;
            data_size     <= 3'h7;
          end
        end

        S_WAIT: begin
          if (!transfer_complete) state <= pending;
        end

        S_STOP: begin
          if (send_stop_bit && transfer_complete) begin
            send_stop_bit <= 1'b0;
            state         <= S_EVAL;
          end else begin
            send_stop_bit <= 1'b1;
          end
        end

        S_EVAL: begin
          if (!nack_flag) begin
            state <= S_NEXT;
          end else if (retry_cnt < RETRY_MAX) begin
            retry_cnt <= retry_cnt + 3'd1;
            gap_cnt   <= '0;
            state     <= S_GAP;
          end else begin
            auto_init_error <= 1'b1;
            if (!auto_init_error || clear_error) error_index <= rom_address;
            state <= S_NEXT;
          end
        end

        S_GAP: begin
          if (gap_cnt >= GAP_LAST) begin
            gap_cnt <= '0;
            state   <= S_START;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end

        S_NEXT: begin
          rom_address <= rom_address + 1'b1;
          retry_cnt   <= '0;
          state       <= S_CHECK;
        end

        S_DONE: begin
          if (restart) begin
            rom_address <= '0;
            state       <= S_CHECK;
          end
        end

        default: begin
          transfer_data  <= 1'b0;
          send_start_bit <= 1'b0;
          send_stop_bit  <= 1'b0;
          state          <= S_CHECK;
        end
      endcase
    end
  end

endmodule
